video_timing_detector: RTL and testbench
========================================

// Module: video_timing_detector
// PURPOSE
//  Receive-side counterpart of video_timing_fsm. Watches a pixel stream (vsync/hsync/de/RGB) on the
//  pclk domain, measures frame geometry, compares it against the expected timing and reports lock,
//  errors and a per-frame pixel checksum. Sits on video_timing_fsm or line_buf_ctrl_top outputs as a
//  self-checking monitor.
// PARAMETERS
//  VSYNC_POL  0   vsync polarity, 0 active high, 1 active low
//  HSYNC_POL  0   hsync polarity, 0 active high, 1 active low
//  WIDTH      10  bits per colour channel
//  CNT_W      12  width of measurement counters
//  EXP_HTOT   15  expected pclk per line (HSW+HBP+HACT+HFP)
//  EXP_HACT   10  expected DE-high pclk per active line
//  EXP_VTOT   7   expected lines per frame
//  EXP_VACT   4   expected lines containing DE per frame
// PORTS
//  pclk         in   1      pixel clock
//  rstn         in   1      async active-low reset
//  i_en         in   1      detector enable
//  i_clr_err    in   1      clears sticky o_err bits
//  i_vsync      in   1      vertical sync
//  i_hsync      in   1      horizontal sync
//  i_de         in   1      data enable
//  i_r/i_g/i_b  in   WIDTH  pixel data, valid when i_de=1
//  o_htot       out  CNT_W  measured line period (last full line of frame)
//  o_hact       out  CNT_W  DE count of last active line
//  o_vtot       out  CNT_W  measured lines per frame
//  o_vact       out  CNT_W  measured active lines per frame
//  o_checksum   out  32     sum mod 2^32 of {r,g,b} over all DE pixels of frame
//  o_frame_cnt  out  16     completed frames, wraps
//  o_frame_done out  1      1-cycle pulse when measurements update
//  o_locked     out  1      last frame matched all EXP_* values
//  o_err        out  4      sticky {vact,vtot,hact,htot} mismatch flags
// BEHAVIOUR
//  - rstn=0 (async): all outputs 0, state SEARCH, all counters 0.
//  - vs=i_vsync^VSYNC_POL, hs=i_hsync^HSYNC_POL; edge = vs & ~vs_q (1 reg); same for hs.
//  - htot: pclk between consecutive hs edges (edge-to-edge). vtot: hs edges from one vs edge
//    (inclusive, incl. same-cycle hs) up to next vs edge (exclusive). vact: lines with >=1 DE cycle.
//  - hact per line: DE cycles between hs edges; any active line != EXP_HACT sets hact mismatch.
//  - Counters saturate at 2^CNT_W-1 (no wrap); saturated value always mismatches.
//  - Simultaneous vs+hs edge: close old frame and start line 1 of new frame in same cycle.
//  - FSM: SEARCH -vs edge-> MEASURE (no frame_done, discards partial frame).
//    MEASURE/LOCKED -vs edge-> latch o_htot/o_hact/o_vtot/o_vact/o_checksum, frame_done=1,
//    frame_cnt++, all match -> LOCKED, else -> MEASURE with o_locked=0.
//  - Outputs update registered, 1 cycle after vs edge cycle; o_locked updates with frame_done.
//  - o_err bits set on mismatch at frame end, hold until i_clr_err; set wins over clear same cycle.
//  - i_en=0: sync return to SEARCH, o_locked=0, counters cleared, latched measurements and
//    frame_cnt held. i_en rising restarts from SEARCH.
//  - Reset mid-frame: immediate clear; first report only after two vs edges.
// TESTING
//  - Default timing, 5 frames -> 4 frame_done pulses, o_htot=15 o_hact=10 o_vtot=7 o_vact=4,
//    o_locked=1 after 1st pulse, o_err=0, o_frame_cnt=4.
//  - Constant RGB r=g=b=10'h001, 5 frames -> o_checksum=40*30'h0010_0401=32'h0280_A028 per frame.
//  - HACT=9 in DUT stimulus -> o_hact=9, o_err=4'b0010, o_locked=0; i_clr_err -> o_err=0 only if
//    next frame clean.
//  - VSYNC_POL=1 and HSYNC_POL=1 generator + detector -> same results as default case.
//  - Assert rstn low mid frame 2 -> outputs 0 immediately; lock reacquired after 2 vs edges.
//  - i_en low for 30 cycles mid-stream -> o_locked=0, o_frame_cnt frozen, relock after re-enable.

Source files
------------

// File: rtl/video_timing_detector.sv
// Receive-side video timing monitor. Measures line/frame geometry from the
// sync and DE stream, compares it with the expected timing, and reports
// lock, sticky mismatch flags and a per-frame pixel checksum.
module video_timing_detector #(
   parameter logic        VSYNC_POL = 1'b0,
   parameter logic        HSYNC_POL = 1'b0,
   parameter int unsigned WIDTH     = 10,
   parameter int unsigned CNT_W     = 12,
   parameter int unsigned EXP_HTOT  = 15,
   parameter int unsigned EXP_HACT  = 10,
   parameter int unsigned EXP_VTOT  = 7,
   parameter int unsigned EXP_VACT  = 4
) (
   input  logic             pclk,
   input  logic             rstn,
   input  logic             i_en,
   input  logic             i_clr_err,
   input  logic             i_vsync,
   input  logic             i_hsync,
   input  logic             i_de,
   input  logic [WIDTH-1:0] i_r,
   input  logic [WIDTH-1:0] i_g,
   input  logic [WIDTH-1:0] i_b,
   output logic [CNT_W-1:0] o_htot,
   output logic [CNT_W-1:0] o_hact,
   output logic [CNT_W-1:0] o_vtot,
   output logic [CNT_W-1:0] o_vact,
   output logic [31:0]      o_checksum,
   output logic [15:0]      o_frame_cnt,
   output logic             o_frame_done,
   output logic             o_locked,
   output logic [3:0]       o_err
);

   typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] HTOT_E  = CNT_W'(EXP_HTOT);
   localparam logic [CNT_W-1:0] HACT_E  = CNT_W'(EXP_HACT);
   localparam logic [CNT_W-1:0] VTOT_E  = CNT_W'(EXP_VTOT);
   localparam logic [CNT_W-1:0] VACT_E  = CNT_W'(EXP_VACT);

   state_t           state;
   logic             vs, hs, vs_q, hs_q, vs_edge, hs_edge;
   logic [CNT_W-1:0] hcnt, line_htot, hact_cnt, last_hact, vcnt, vact_cnt;
   logic             hact_bad;
   logic [31:0]      sum, pix;
   logic             line_active, rep_hbad, report;
   logic [CNT_W-1:0] rep_htot, rep_hact, rep_vact;
   logic [3:0]       mism;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == CNT_MAX) ? v : v + CNT_W'(1);
   endfunction

   // A saturated counter never counts as a match.
   function automatic logic miss(input logic [CNT_W-1:0] v, input logic [CNT_W-1:0] e);
      return (v != e) || (v == CNT_MAX);
   endfunction

   assign vs      = i_vsync ^ VSYNC_POL;
   assign hs      = i_hsync ^ HSYNC_POL;
   assign vs_edge = vs & ~vs_q;
   assign hs_edge = hs & ~hs_q;
   assign pix     = 32'({i_r, i_g, i_b});

   // Frame-close view: folds in the line that closes in the vsync-edge cycle.
   always_comb begin
      line_active = (hact_cnt != '0);
      rep_htot    = hs_edge ? hcnt : line_htot;
      rep_hact    = line_active ? hact_cnt : last_hact;
      rep_vact    = line_active ? sat_inc(vact_cnt) : vact_cnt;
      rep_hbad    = hact_bad | (line_active & miss(hact_cnt, HACT_E));
      mism        = {miss(rep_vact, VACT_E), miss(vcnt, VTOT_E), rep_hbad, miss(rep_htot, HTOT_E)};
      report      = i_en & vs_edge & (state != SEARCH);
   end

   // Sync edge registers and per-line / per-frame measurement counters.
   always_ff @(posedge pclk or negedge rstn) begin
      if (!rstn) begin
         vs_q      <= 1'b0;
         hs_q      <= 1'b0;
         hcnt      <= '0;
         line_htot <= '0;
         hact_cnt  <= '0;
         last_hact <= '0;
         vcnt      <= '0;
         vact_cnt  <= '0;
         hact_bad  <= 1'b0;
         sum       <= '0;
      end else begin
         vs_q <= vs;
         hs_q <= hs;
         if (!i_en) begin
            hcnt      <= '0;
            line_htot <= '0;
            hact_cnt  <= '0;
            last_hact <= '0;
            vcnt      <= '0;
            vact_cnt  <= '0;
            hact_bad  <= 1'b0;
            sum       <= '0;
         end else begin
            // The edge cycle is the first cycle of the new line.
            hcnt <= hs_edge ? CNT_W'(1) : sat_inc(hcnt);
            if (hs_edge)
               line_htot <= hcnt;
            if (vs_edge | hs_edge) begin
               hact_cnt <= i_de ? CNT_W'(1) : '0;
               if (line_active)
                  last_hact <= hact_cnt;
            end else if (i_de) begin
               hact_cnt <= sat_inc(hact_cnt);
            end
            if (vs_edge) begin
               vcnt     <= hs_edge ? CNT_W'(1) : '0;
               vact_cnt <= '0;
               hact_bad <= 1'b0;
               sum      <= i_de ? pix : '0;
            end else begin
               if (hs_edge) begin
                  vcnt     <= sat_inc(vcnt);
                  vact_cnt <= rep_vact;
                  hact_bad <= rep_hbad;
               end
               if (i_de)
                  sum <= sum + pix;
            end
         end
      end
   end

   // Lock FSM with registered reporting outputs and sticky error flags.
   always_ff @(posedge pclk or negedge rstn) begin
      if (!rstn) begin
         state        <= SEARCH;
         o_htot       <= '0;
         o_hact       <= '0;
         o_vtot       <= '0;
         o_vact       <= '0;
         o_checksum   <= '0;
         o_frame_cnt  <= '0;
         o_frame_done <= 1'b0;
         o_locked     <= 1'b0;
         o_err        <= '0;
      end else begin
         o_frame_done <= report;
         o_err        <= (i_clr_err ? 4'b0000 : o_err) | (report ? mism : 4'b0000);
         if (!i_en) begin
            state    <= SEARCH;
            o_locked <= 1'b0;
         end else if (vs_edge) begin
            if (state == SEARCH) begin
               state <= MEASURE;
            end else begin
               o_htot      <= rep_htot;
               o_hact      <= rep_hact;
               o_vtot      <= vcnt;
               o_vact      <= rep_vact;
               o_checksum  <= sum;
               o_frame_cnt <= o_frame_cnt + 16'd1;
               o_locked    <= (mism == 4'b0000);
               state       <= (mism == 4'b0000) ? LOCKED : MEASURE;
            end
         end
      end
   end

endmodule

// File: tb/tb_video_timing_detector.sv
// Bench for video_timing_detector: a frame generator drives two detectors
// (default and inverted sync polarity) and a geometry-level model predicts
// every frame report.
module tb_video_timing_detector;
   localparam int HSW = 2, HBP = 2, HTOT = 15, VSW = 1, VBP = 1;

   logic pclk = 1'b0, rstn = 1'b0, en = 1'b0, clr = 1'b0;
   logic vs = 1'b0, hs = 1'b0, de = 1'b0;
   logic [9:0]  r = '0, g = '0, b = '0;
   logic [11:0] a_htot, a_hact, a_vtot, a_vact, b_htot, b_hact, b_vtot, b_vact;
   logic [31:0] a_sum, b_sum;
   logic [15:0] a_cnt, b_cnt;
   logic        a_done, b_done, a_lock, b_lock;
   logic [3:0]  a_err, b_err;

   // model state
   bit          m_search;
   logic [31:0] e_htot, e_hact, e_vtot, e_vact, e_sum, e_cnt, e_err, e_lock, e_done;
   int          pf_htot, pf_hact, pf_vtot, pf_vact;
   logic [31:0] pf_sum, cur_sum;
   int          n_chk = 0, n_pass = 0;

   always #5 pclk = ~pclk;

   video_timing_detector dut_p (
      .pclk(pclk), .rstn(rstn), .i_en(en), .i_clr_err(clr),
      .i_vsync(vs), .i_hsync(hs), .i_de(de), .i_r(r), .i_g(g), .i_b(b),
      .o_htot(a_htot), .o_hact(a_hact), .o_vtot(a_vtot), .o_vact(a_vact),
      .o_checksum(a_sum), .o_frame_cnt(a_cnt), .o_frame_done(a_done),
      .o_locked(a_lock), .o_err(a_err));

   video_timing_detector #(.VSYNC_POL(1'b1), .HSYNC_POL(1'b1)) dut_n (
      .pclk(pclk), .rstn(rstn), .i_en(en), .i_clr_err(clr),
      .i_vsync(~vs), .i_hsync(~hs), .i_de(de), .i_r(r), .i_g(g), .i_b(b),
      .o_htot(b_htot), .o_hact(b_hact), .o_vtot(b_vtot), .o_vact(b_vact),
      .o_checksum(b_sum), .o_frame_cnt(b_cnt), .o_frame_done(b_done),
      .o_locked(b_lock), .o_err(b_err));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic chk2(input string tag, input logic [31:0] p, input logic [31:0] n,
                       input logic [31:0] exp);
      chk({tag, "/pos"}, p, exp);
      chk({tag, "/neg"}, n, exp);
   endtask

   task automatic check_report();
      chk2("done", 32'(a_done), 32'(b_done), e_done);
      chk2("htot", 32'(a_htot), 32'(b_htot), e_htot);
      chk2("hact", 32'(a_hact), 32'(b_hact), e_hact);
      chk2("vtot", 32'(a_vtot), 32'(b_vtot), e_vtot);
      chk2("vact", 32'(a_vact), 32'(b_vact), e_vact);
      chk2("csum", a_sum, b_sum, e_sum);
      chk2("lock", 32'(a_lock), 32'(b_lock), e_lock);
      chk2("fcnt", 32'(a_cnt), 32'(b_cnt), e_cnt);
      chk2("err",  32'(a_err), 32'(b_err), e_err);
   endtask

   task automatic reset_model();
      m_search = 1'b1;
      e_htot = 0; e_hact = 0; e_vtot = 0; e_vact = 0; e_sum = 0;
      e_cnt = 0; e_err = 0; e_lock = 0; e_done = 0;
   endtask

   // Model of what happens at a frame start (vsync edge).
   task automatic model_vs_edge(input bit clr_now);
      logic [3:0] mm;
      if (clr_now) e_err = 0;
      if (m_search) begin
         m_search = 1'b0;
         e_done   = 0;
      end else begin
         mm = {pf_vact != 4, pf_vtot != 7, pf_hact != 10, pf_htot != 15};
         e_htot = pf_htot; e_hact = pf_hact; e_vtot = pf_vtot; e_vact = pf_vact;
         e_sum  = pf_sum;
         e_cnt  = (e_cnt + 1) & 32'hFFFF;
         e_err  = e_err | 32'(mm);
         e_lock = (mm == 4'b0000) ? 1 : 0;
         e_done = 1;
      end
   endtask

   // One frame: VSW sync lines, VBP lines, vact active lines, vfp lines;
   // each line HSW sync, HBP, hact DE cycles, rest front porch (HTOT total).
   task automatic run_frame(input int hact, input int vact, input int vfp, input int extra,
                            input bit const_pix, input int rst_at, input int en_off_at,
                            input int clr_at);
      int vtot, k, len;
      vtot    = VSW + VBP + vact + vfp;
      k       = 0;
      cur_sum = 0;
      for (int l = 0; l < vtot; l++) begin
         len = HTOT + ((l == vtot - 1) ? extra : 0);
         for (int c = 0; c < len; c++) begin
            @(posedge pclk); #1;
            if (k == 1) check_report();
            if (k == 2) chk2("done_low", 32'(a_done), 32'(b_done), 0);
            if (en_off_at >= 0 && k == en_off_at + 1) begin
               chk2("en_lock", 32'(a_lock), 32'(b_lock), 0);
               chk2("en_fcnt", 32'(a_cnt), 32'(b_cnt), e_cnt);
               chk2("en_htot", 32'(a_htot), 32'(b_htot), e_htot);
            end
            if (clr_at >= 0 && k == clr_at + 1)
               chk2("clr_err", 32'(a_err), 32'(b_err), e_err);
            vs = (l < VSW);
            hs = (c < HSW);
            de = (l >= VSW + VBP) && (l < VSW + VBP + vact) &&
                 (c >= HSW + HBP) && (c < HSW + HBP + hact);
            if (de && const_pix) begin
               r = 10'h001; g = 10'h001; b = 10'h001;
            end else begin
               r = 10'($urandom_range(0, 1023));
               g = 10'($urandom_range(0, 1023));
               b = 10'($urandom_range(0, 1023));
            end
            if (de) cur_sum = cur_sum + {2'b00, r, g, b};
            en  = !(en_off_at >= 0 && k >= en_off_at && k < en_off_at + 30);
            clr = (k == clr_at);
            if (k == 0) model_vs_edge(clr);
            else if (clr) e_err = 0;
            if (en_off_at >= 0 && k == en_off_at) begin
               m_search = 1'b1;
               e_lock   = 0;
            end
            if (rst_at >= 0 && k == rst_at) begin
               rstn = 1'b0;
               #1;
               reset_model();
               check_report();
            end
            if (rst_at >= 0 && k == rst_at + 2) rstn = 1'b1;
            k++;
         end
      end
      pf_htot = (HTOT + extra > 4095) ? 4095 : HTOT + extra;
      pf_hact = hact;
      pf_vtot = vtot;
      pf_vact = vact;
      pf_sum  = cur_sum;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      reset_model();
      pf_htot = 0; pf_hact = 0; pf_vtot = 0; pf_vact = 0; pf_sum = 0;
      #3;
      check_report();
      repeat (3) @(posedge pclk);
      #1;
      rstn = 1'b1;
      en   = 1'b1;

      for (int f = 0; f < 5; f++) run_frame(10, 4, 1, 0, 1'b1, -1, -1, -1);
      chk2("const_csum", a_sum, b_sum, 32'h0280_A028);
      chk2("cnt_after5", 32'(a_cnt), 32'(b_cnt), 4);

      run_frame(9, 4, 1, 0, 1'b0, -1, -1, -1);
      run_frame(10, 4, 1, 0, 1'b0, -1, -1, 50);
      run_frame(10, 4, 1, 0, 1'b0, -1, -1, -1);

      run_frame(10, 4, 1, 5000, 1'b0, -1, -1, -1);
      run_frame(10, 4, 1, 0, 1'b0, -1, -1, 0);
      run_frame(10, 4, 1, 0, 1'b0, -1, -1, 10);

      run_frame(10, 4, 1, 0, 1'b0, 51, -1, -1);
      for (int f = 0; f < 3; f++) run_frame(10, 4, 1, 0, 1'b0, -1, -1, -1);

      run_frame(10, 4, 1, 0, 1'b0, -1, 20, -1);
      for (int f = 0; f < 3; f++) run_frame(10, 4, 1, 0, 1'b0, -1, -1, -1);

      for (int f = 0; f < 8; f++) begin
         int h, va, vf, ca;
         h  = $urandom_range(8, 10);
         va = $urandom_range(3, 4);
         vf = 5 - va + $urandom_range(0, 1);
         ca = ($urandom_range(0, 3) == 0) ? 0 : -1;
         run_frame(h, va, vf, 0, 1'b0, -1, -1, ca);
      end
      run_frame(10, 4, 1, 0, 1'b0, -1, -1, -1);
      run_frame(10, 4, 1, 0, 1'b0, -1, -1, -1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
